// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full and fill-level controller for a dual-clock FIFO.
// Optional sticky overflow output wovf is compiled in when FIFO_WOVF_EN is defined.
module fifo_wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr_gray,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic [ADDRSIZE:0]   wptr
`ifdef FIFO_WOVF_EN
    ,
    output logic                wovf
`endif
);

    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] sync_reg [SYNC_STAGES];
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] rbin_s;

    logic [ADDRSIZE:0] wbin_reg;
    logic [ADDRSIZE:0] wptr_reg;
    logic              wfull_reg;
    logic              walmost_full_reg;
    logic [ADDRSIZE:0] wlevel_reg;

    logic              accept;
    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wgray_next;
    logic [ADDRSIZE:0] wlevel_next;
    logic              wfull_next;
    logic              walmost_full_next;

    // Plain flop chain on the foreign Gray pointer; nothing may sit between stages.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge wclk or posedge wrst) begin
                    if (wrst) begin
                        sync_reg[gi] <= '0;
                    end else begin
                        sync_reg[gi] <= rptr_gray;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge wclk or posedge wrst) begin
                    if (wrst) begin
                        sync_reg[gi] <= '0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign wq_rptr = sync_reg[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
            assign rbin_s[gi] = ^wq_rptr[ADDRSIZE:gi];
        end
    endgenerate

    // Reset gates the accept so the array never sees a write while wrst is high.
    assign accept      = winc & ~wfull_reg & ~wrst;
    assign wbin_next   = wbin_reg + {{ADDRSIZE{1'b0}}, accept};
    assign wgray_next  = (wbin_next >> 1) ^ wbin_next;
    assign wlevel_next = wbin_next - rbin_s;

    assign wfull_next = (wgray_next == {~wq_rptr[ADDRSIZE:ADDRSIZE-1],
                                        wq_rptr[ADDRSIZE-2:0]});
    assign walmost_full_next = (wlevel_next >= AFULL_LVL);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_reg         <= '0;
            wptr_reg         <= '0;
            wfull_reg        <= 1'b0;
            walmost_full_reg <= 1'b0;
            wlevel_reg       <= '0;
        end else begin
            wbin_reg         <= wbin_next;
            wptr_reg         <= wgray_next;
            wfull_reg        <= wfull_next;
            walmost_full_reg <= walmost_full_next;
            wlevel_reg       <= wlevel_next;
        end
    end

    assign wclken       = accept;
    assign waddr        = wbin_reg[ADDRSIZE-1:0];
    assign wfull        = wfull_reg;
    assign walmost_full = walmost_full_reg;
    assign wlevel       = wlevel_reg;
    assign wptr         = wptr_reg;

`ifdef FIFO_WOVF_EN
    logic wovf_reg;

    // Sticky: any write attempted while full sets it until the next reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wovf_reg <= 1'b0;
        end else begin
            wovf_reg <= wovf_reg | (winc & wfull_reg);
        end
    end

    assign wovf = wovf_reg;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fifo_wptr_full;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [4:0] rptr_gray;
    logic       wclken;
    logic [3:0] waddr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic [4:0] wptr;
    logic       wovf;

`ifdef FIFO_WOVF_EN
    localparam int M_OVF = 64;
`else
    localparam int M_OVF = 0;
    assign wovf = 1'b0;
`endif
    localparam int M_EN   = 1;
    localparam int M_ADDR = 2;
    localparam int M_FULL = 4;
    localparam int M_AF   = 8;
    localparam int M_LVL  = 16;
    localparam int M_PTR  = 32;
    localparam int M_ALL  = 63 | M_OVF;

    typedef struct {
        string      name;
        bit [6:0]   mask;
        logic       wclken;
        logic [3:0] waddr;
        logic       wfull;
        logic       walmost_full;
        logic [4:0] wlevel;
        logic [4:0] wptr;
        logic       wovf;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    fifo_wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(12), .SYNC_STAGES(2)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .rptr_gray   (rptr_gray),
        .wclken      (wclken),
        .waddr       (waddr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .wptr        (wptr)
`ifdef FIFO_WOVF_EN
        ,
        .wovf        (wovf)
`endif
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    function automatic exp_t mk(input string n, input int m, input logic en, input int addr,
                                input logic full, input logic af, input int lvl, input int ptr,
                                input logic ovf);
        exp_t e;
        e.name         = n;
        e.mask         = m[6:0];
        e.wclken       = en;
        e.waddr        = addr[3:0];
        e.wfull        = full;
        e.walmost_full = af;
        e.wlevel       = lvl[4:0];
        e.wptr         = ptr[4:0];
        e.wovf         = ovf;
        return e;
    endfunction

    task automatic step(input logic r, input logic i, input logic [4:0] rp, input exp_t e);
        @(posedge wclk);
        #1;
        wrst      = r;
        winc      = i;
        rptr_gray = rp;
        sb.push_back(e);
    endtask

    task automatic chk(input string n, input string f, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s %s: got %0d, expected %0d", n, f, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mask[0]) chk(e.name, "wclken", {4'b0, wclken}, {4'b0, e.wclken});
                if (e.mask[1]) chk(e.name, "waddr", {1'b0, waddr}, {1'b0, e.waddr});
                if (e.mask[2]) chk(e.name, "wfull", {4'b0, wfull}, {4'b0, e.wfull});
                if (e.mask[3]) chk(e.name, "walmost_full", {4'b0, walmost_full}, {4'b0, e.walmost_full});
                if (e.mask[4]) chk(e.name, "wlevel", wlevel, e.wlevel);
                if (e.mask[5]) chk(e.name, "wptr", wptr, e.wptr);
                if (e.mask[6]) chk(e.name, "wovf", {4'b0, wovf}, {4'b0, e.wovf});
                $display("txn %s: wclken=%0d waddr=%0d wfull=%0d waf=%0d wlevel=%0d wptr=%b wovf=%0d",
                         e.name, wclken, waddr, wfull, walmost_full, wlevel, wptr, wovf);
            end
        end
    end

    initial begin
        int r3;
        wrst      = 1'b1;
        winc      = 1'b0;
        rptr_gray = 5'd0;

        step(1, 0, 0, mk("reset", M_ALL, 0, 0, 0, 0, 0, 0, 0));

        // Burst of 7 writes, then reset asserted mid-cycle with winc still high.
        for (int i = 0; i < 7; i++)
            step(0, 1, 0, mk("burst", M_EN | M_ADDR | M_PTR, 1, i, 0, 0, 0, gray(i), 0));
        step(1, 1, 0, mk("midreset", M_ALL, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, mk("midreset_hold", M_ALL, 0, 0, 0, 0, 0, 0, 0));

        // Fill 16 with read pointer parked at 0.
        for (int i = 0; i < 16; i++)
            step(0, 1, 0, mk("fill", M_EN | M_ADDR | M_FULL | M_LVL | M_PTR, 1, i, 0, 0, i, gray(i), 0));

        // Writes while full are dropped; overflow latches one edge after the first attempt.
        step(0, 1, 0, mk("ovf0", M_ALL, 0, 0, 1, 1, 16, 5'b11000, 0));
        step(0, 1, 0, mk("ovf1", M_ALL, 0, 0, 1, 1, 16, 5'b11000, 1));
        step(0, 1, 0, mk("ovf2", M_ALL, 0, 0, 1, 1, 16, 5'b11000, 1));
        step(0, 0, 0, mk("ovf_hold", M_ALL, 0, 0, 1, 1, 16, 5'b11000, 1));

        // Read frees one slot together with a write attempt: write is dropped.
        step(0, 1, 1, mk("rel0", M_EN | M_FULL | M_LVL | M_PTR, 0, 0, 1, 1, 16, 5'b11000, 0));
        step(0, 0, 1, mk("rel1", M_EN | M_FULL | M_LVL | M_PTR, 0, 0, 1, 1, 16, 5'b11000, 0));
        step(0, 0, 1, mk("rel2", M_FULL | M_LVL | M_PTR, 0, 0, 1, 1, 16, 5'b11000, 0));
        step(0, 0, 1, mk("rel3", M_FULL | M_LVL | M_AF | M_PTR, 0, 0, 0, 1, 15, 5'b11000, 0));

        // Almost-full threshold at 12.
        step(1, 0, 0, mk("af_reset", M_ALL, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++)
            step(0, 1, 0, mk("af_fill", M_EN | M_ADDR | M_FULL | M_AF | M_LVL | M_PTR,
                             1, i, 0, 0, i, gray(i), 0));
        step(0, 0, 0, mk("af_12", M_EN | M_FULL | M_AF | M_LVL | M_PTR, 0, 0, 0, 1, 12, gray(12), 0));

        // Wrap: continuous writes with the reader trailing so the level settles at 4.
        step(1, 0, 0, mk("wrap_reset", M_ALL, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 44; k++) begin
            r3 = (k - 3 >= 1) ? (k - 4) : 0;
            step(0, 1, (k >= 1) ? gray(k - 1) : 5'd0,
                 mk("wrap", M_EN | M_ADDR | M_FULL | M_AF | M_LVL | M_PTR,
                    1, k % 16, 0, 0, k - r3, gray(k % 32), 0));
        end
        step(0, 0, gray(43), mk("wrap_idle", M_EN | M_FULL, 0, 0, 0, 0, 0, 0, 0));

        for (int n = 0; n < 5 && sb.size() > 0; n++) @(negedge wclk);
        @(negedge wclk);
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side pointer and flag controller for the dual-clock FIFO. Sits directly upstream of the FIFO storage array and runs entirely in the write clock domain. It supplies the array's write address, write enable and full flag. It also exports the Gray-coded write pointer toward the read domain and synchronizes the read domain's Gray pointer to derive full, almost-full and fill level.

Parameters:
- ADDRSIZE, 4, storage address width; FIFO depth = 1<<ADDRSIZE; legal range >= 2.
- AFULL_THRESH, 12, fill level at or above which walmost_full asserts; legal range 1..(1<<ADDRSIZE).
- SYNC_STAGES, 2, flop count in the read-pointer synchronizer; legal range >= 2.

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  asynchronous active-high reset.
- winc  in  1  write request from producer; a write is accepted when winc=1 and wfull=0.
- rptr_gray  in  ADDRSIZE+1  read-domain Gray pointer; asynchronous to wclk.
- wclken  out  1  write enable to the storage array.
- waddr  out  ADDRSIZE  write address to the storage array.
- wfull  out  1  FIFO full, registered.
- walmost_full  out  1  fill level >= AFULL_THRESH, registered.
- wlevel  out  ADDRSIZE+1  fill level as seen from the write domain, 0..DEPTH, registered.
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchronizer.
- wovf  out  1  sticky overflow flag; present only with FIFO_WOVF_EN.

Behaviour:
- Reset: asynchronous on wrst rising; immediate effect. All flops clear to 0: synchronizer chain, wbin, wptr, wfull, walmost_full, wlevel, wovf. Outputs read 0 while wrst=1. Reset mid-burst discards all pointer state; no partial write occurs because wclken=0 during reset.
- Synchronizer: SYNC_STAGES-flop chain on rptr_gray produces wq_rptr. No logic between stages.
- Pointer state: wbin is an (ADDRSIZE+1)-bit binary counter. wptr is its registered Gray image.
- Next-state equations:
  - accept = winc & ~wfull.
  - wbin_next = wbin + accept, modulo 2^(ADDRSIZE+1). Wrap is natural; the MSB is the lap bit.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Combinational outputs:
  - waddr = wbin[ADDRSIZE-1:0].
  - wclken = accept. Zero-latency: data and address are valid in the same cycle as winc.
- Full, registered every edge: wfull <= (wgray_next == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]}). Asserts on the edge that accepts the DEPTH-th outstanding write.
- Level and almost-full:
  - rbin_s = Gray-to-binary of wq_rptr (XOR prefix from the MSB).
  - wlevel <= wbin_next - rbin_s, modulo 2^(ADDRSIZE+1).
  - walmost_full <= (wbin_next - rbin_s) >= AFULL_THRESH.
- Write while full: ignored. wbin and wptr hold, wclken=0, wfull stays 1.
- Pessimism is intentional:
  - After the read side frees a slot, wfull, wlevel and walmost_full update exactly SYNC_STAGES+1 wclk edges after rptr_gray changes.
  - Flags never report less fill than actual.
- Simultaneous winc and read-pointer change: the write is evaluated against the old synchronized pointer. If wfull=1, the write is dropped. The next cycle reflects both events.
- wptr changes at most 1 bit per edge. It is registered with no glitches, and is safe for the read-domain synchronizer.
- Exactly one state-holding counter; no FSM beyond the counter and flags.

Optional Feature:
- Macro FIFO_WOVF_EN.
- Defined:
  - Port wovf exists.
  - wovf <= wovf | (winc & wfull): sets on any write attempted while full.
  - Cleared only by wrst.
  - No effect on pointers or flags.
- Undefined: port wovf and its flop are absent; writes while full are dropped silently.

Test Plan:
- Reset: wrst pulsed mid-burst with wbin=7 -> waddr, wptr, wfull, wlevel, walmost_full, wovf all 0 before the next wclk edge; first write after release uses waddr=0.
- Fill (ADDRSIZE=4), rptr_gray held 0:
  - Stimulus: 16 consecutive winc.
  - wclken=1 and waddr=0..15 during the 16 accepted writes.
  - Edge after the 16th write: wfull=1, wlevel=16, wptr=5'b11000.
- Overflow (FIFO_WOVF_EN defined), state after the fill test:
  - Stimulus: winc=1 for 3 cycles.
  - wclken=0, waddr stays 0, wptr stays 5'b11000, wovf=1 and remains 1 after winc drops.
- Almost-full, AFULL_THRESH=12: 11 writes -> walmost_full=0, wlevel=11; 12th write -> walmost_full=1, wlevel=12.
- Release latency: full FIFO, rptr_gray changed 00000->00001 -> wfull=0 and wlevel=15 on exactly the 3rd wclk edge after the change (SYNC_STAGES=2); unchanged on edges 1-2.
- Wrap:
  - Stimulus: 40 writes with rptr_gray advancing to keep level at 4.
  - wbin wraps 31->0; every wptr transition differs by exactly 1 bit; wfull never asserts; wlevel stays in 3..5.
